// File: rtl/shift_rotate_pipe_if.sv
// Handshake bundle for the shift/rotate pipe: operation request side (in_*)
// and result side (out_*), each with its own valid/ready pair.
interface shift_rotate_pipe_if #(
   parameter int TAG_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_data;
   logic [4:0]       in_shamt;
   logic [1:0]       in_op;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_data;
   logic [TAG_W-1:0] out_tag;

   modport master (
      output in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
      input  in_ready, out_valid, out_data, out_tag
   );

   modport slave (
      input  in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
      output in_ready, out_valid, out_data, out_tag
   );
endinterface

// File: rtl/shift_rotate_pipe.sv
// Five-stage 32-bit shift/rotate pipe (SLL, SRL, SRA, ROTR). Stage k applies
// a 2^k-bit step when shamt bit k is set; the whole pipe stalls as one unit.
module shift_rotate_pipe #(
   parameter int TAG_W = 4
) (
   input  logic               clock,
   input  logic               reset_n,
   shift_rotate_pipe_if.slave bus
);
   localparam int STAGES = 5;

   typedef enum logic [1:0] {
      OP_SLL  = 2'b00,
      OP_SRL  = 2'b01,
      OP_SRA  = 2'b10,
      OP_ROTR = 2'b11
   } op_e;

   // Once stage 0 has shifted an SRA operand, bit 31 already holds the sign,
   // so every later stage can fill from its own bit 31.
   function automatic logic [31:0] stepShift(input logic [31:0] d, input op_e op, input int amt);
      logic [31:0] result;
      logic [63:0] wide;
      result = d;
      wide   = '0;
      case (op)
         OP_SLL:  result = d << amt;
         OP_SRL:  result = d >> amt;
         OP_SRA: begin
            wide   = {{32{d[31]}}, d} >> amt;
            result = wide[31:0];
         end
         OP_ROTR: begin
            wide   = {d, d} >> amt;
            result = wide[31:0];
         end
         default: result = d;
      endcase
      return result;
   endfunction

   logic [STAGES-1:0] validReg;
   logic [31:0]       dataReg  [STAGES];
   logic [4:0]        shamtReg [STAGES-1];
   op_e               opReg    [STAGES-1];
   logic [TAG_W-1:0]  tagReg   [STAGES];

   logic [31:0]       srcData  [STAGES];
   logic [4:0]        srcShamt [STAGES];
   op_e               srcOp    [STAGES];
   logic [TAG_W-1:0]  srcTag   [STAGES];
   logic [31:0]       dataNext [STAGES];

   logic advance;

   assign advance      = !validReg[STAGES-1] || bus.out_ready;
   assign bus.in_ready = advance;

   for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_head
         assign srcData[gi]  = bus.in_data;
         assign srcShamt[gi] = bus.in_shamt;
         assign srcOp[gi]    = op_e'(bus.in_op);
         assign srcTag[gi]   = bus.in_tag;
      end else begin : g_body
         assign srcData[gi]  = dataReg[gi-1];
         assign srcShamt[gi] = shamtReg[gi-1];
         assign srcOp[gi]    = opReg[gi-1];
         assign srcTag[gi]   = tagReg[gi-1];
      end
      assign dataNext[gi] = srcShamt[gi][gi] ? stepShift(srcData[gi], srcOp[gi], 1 << gi)
                                             : srcData[gi];
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         validReg <= '0;
         for (int k = 0; k < STAGES; k++) begin
            dataReg[k] <= '0;
            tagReg[k]  <= '0;
         end
         for (int k = 0; k < STAGES - 1; k++) begin
            shamtReg[k] <= '0;
            opReg[k]    <= OP_SLL;
         end
      end else if (advance) begin
         // in_ready equals advance, so in_valid alone marks an accepted op here.
         validReg <= {validReg[STAGES-2:0], bus.in_valid};
         for (int k = 0; k < STAGES; k++) begin
            dataReg[k] <= dataNext[k];
            tagReg[k]  <= srcTag[k];
         end
         for (int k = 0; k < STAGES - 1; k++) begin
            shamtReg[k] <= srcShamt[k];
            opReg[k]    <= srcOp[k];
         end
      end
   end

   assign bus.out_valid = validReg[STAGES-1];
   assign bus.out_data  = dataReg[STAGES-1];
   assign bus.out_tag   = tagReg[STAGES-1];
endmodule

// File: tb/tb_shift_rotate_pipe.sv
// Scoreboard bench for shift_rotate_pipe: stimulus pushes expected results,
// an independent monitor pops and compares whenever a result is offered.
module tb_shift_rotate_pipe;
   localparam int TAG_W = 4;

   typedef struct {
      logic [31:0]      data;
      logic [TAG_W-1:0] tag;
      bit               chkLat;
      int               issueCyc;
   } exp_t;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   bit   soakOn = 1'b0;
   exp_t expQ[$];

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   shift_rotate_pipe_if #(.TAG_W(TAG_W)) bus ();
   shift_rotate_pipe #(.TAG_W(TAG_W)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic logic [31:0] refModel(input logic [31:0] d, input logic [4:0] s, input logic [1:0] op);
      case (op)
         2'b00:   return d << s;
         2'b01:   return d >> s;
         2'b10:   return 32'($signed(d) >>> s);
         default: return (s == 5'd0) ? d : ((d >> s) | (d << (32 - int'(s))));
      endcase
   endfunction

   // Presents one op and holds it until accepted; track=0 ops are not expected back.
   task automatic issue(input logic [31:0] d, input logic [4:0] s, input logic [1:0] op,
                        input logic [TAG_W-1:0] tag, input logic [31:0] expData,
                        input bit track, input bit chkLat);
      exp_t e;
      int   waitN;
      waitN = 0;
      @(negedge clock);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_shamt = s;
      bus.in_op    = op;
      bus.in_tag   = tag;
      #1;
      while (!bus.in_ready && waitN < 1000) begin
         @(negedge clock);
         #1;
         waitN++;
      end
      if (!bus.in_ready) begin
         check("issue_accept", {63'd0, bus.in_ready}, 64'd1);
      end else if (track) begin
         e.data     = expData;
         e.tag      = tag;
         e.chkLat   = chkLat;
         e.issueCyc = cyc;
         expQ.push_back(e);
      end
      @(posedge clock);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (expQ.size() != 0 && n < 300) begin
         @(negedge clock);
         n++;
      end
      check("drain_empty", 64'(expQ.size()), 64'd0);
   endtask

   // Monitor: samples 3 time units before each rising edge.
   initial begin
      logic [31:0]      heldData;
      logic [TAG_W-1:0] heldTag;
      bit               stalled;
      exp_t             e;
      stalled  = 1'b0;
      heldData = '0;
      heldTag  = '0;
      forever begin
         @(negedge clock);
         #2;
         if (!reset_n) begin
            stalled = 1'b0;
            continue;
         end
         if (stalled) begin
            check("hold_valid", {63'd0, bus.out_valid}, 64'd1);
            check("hold_data", {32'd0, bus.out_data}, {32'd0, heldData});
            check("hold_tag", {60'd0, bus.out_tag}, {60'd0, heldTag});
         end
         if (bus.out_valid) begin
            if (expQ.size() == 0) begin
               check("unexpected_out", {63'd0, bus.out_valid}, 64'd0);
            end else begin
               if (!stalled && expQ[0].chkLat)
                  check("latency", 64'(cyc - expQ[0].issueCyc), 64'd5);
               if (bus.out_ready) begin
                  e = expQ.pop_front();
                  check("out_data", {32'd0, bus.out_data}, {32'd0, e.data});
                  check("out_tag", {60'd0, bus.out_tag}, {60'd0, e.tag});
               end
            end
         end
         stalled  = bus.out_valid && !bus.out_ready;
         heldData = bus.out_data;
         heldTag  = bus.out_tag;
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] word;
      logic [4:0]  s;
      logic [1:0]  op;
      logic [31:0] d;

      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_shamt  = '0;
      bus.in_op     = '0;
      bus.in_tag    = '0;
      bus.out_ready = 1'b1;
      reset_n       = 1'b0;
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      #1;
      check("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
      check("reset_out_data", {32'd0, bus.out_data}, 64'd0);
      check("reset_out_tag", {60'd0, bus.out_tag}, 64'd0);
      check("reset_in_ready", {63'd0, bus.in_ready}, 64'd1);

      // Directed vectors with hand-computed results.
      issue(32'h00000001, 5'd31, 2'b00, 4'd1, 32'h80000000, 1, 1);
      drain();
      issue(32'h80000000, 5'd4, 2'b10, 4'd2, 32'hF8000000, 1, 1);
      issue(32'h80000000, 5'd4, 2'b01, 4'd3, 32'h08000000, 1, 1);
      drain();
      issue(32'h12345678, 5'd8, 2'b11, 4'd4, 32'h78123456, 1, 1);
      issue(32'h12345678, 5'd0, 2'b11, 4'd5, 32'h12345678, 1, 1);
      issue(32'h80000001, 5'd1, 2'b11, 4'd6, 32'hC0000000, 1, 1);
      issue(32'h80000000, 5'd31, 2'b10, 4'd7, 32'hFFFFFFFF, 1, 1);
      issue(32'h7FFFFFFF, 5'd31, 2'b10, 4'd8, 32'h00000000, 1, 1);
      issue(32'h0000FFFF, 5'd16, 2'b00, 4'd9, 32'hFFFF0000, 1, 1);
      issue(32'hDEADBEEF, 5'd0, 2'b00, 4'd10, 32'hDEADBEEF, 1, 1);
      issue(32'hDEADBEEF, 5'd0, 2'b01, 4'd11, 32'hDEADBEEF, 1, 1);
      issue(32'hDEADBEEF, 5'd0, 2'b10, 4'd12, 32'hDEADBEEF, 1, 1);
      issue(32'hF0F0F0F0, 5'd12, 2'b01, 4'd13, 32'h000F0F0F, 1, 1);
      drain();

      // Every rotate amount on one random word.
      word = $urandom();
      for (int i = 0; i < 32; i++)
         issue(word, 5'(i), 2'b11, 4'(i), refModel(word, 5'(i), 2'b11), 1, 1);
      drain();

      // Backpressure: 4-cycle stall right after the first result appears.
      fork
         begin
            for (int n = 0; n < 100; n++) begin
               @(negedge clock);
               if (bus.out_valid) break;
            end
            for (int j = 0; j < 4; j++) begin
               bus.out_ready = 1'b0;
               #1;
               check("stall_in_ready", {63'd0, bus.in_ready}, 64'd0);
               if (j < 3) @(negedge clock);
            end
            @(negedge clock);
            bus.out_ready = 1'b1;
         end
         begin
            for (int i = 0; i < 8; i++)
               issue(32'h00000001, 5'(i), 2'b00, 4'(i), 32'h00000001 << i, 1, i == 0);
         end
      join
      drain();

      // Reset with three ops in flight; one held in_valid during reset.
      issue(32'hAAAA5555, 5'd3, 2'b00, 4'd1, 32'h0, 0, 0);
      issue(32'hAAAA5555, 5'd3, 2'b01, 4'd2, 32'h0, 0, 0);
      issue(32'hAAAA5555, 5'd3, 2'b11, 4'd3, 32'h0, 0, 0);
      @(negedge clock);
      reset_n      = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h0BADF00D;
      bus.in_tag   = 4'hF;
      #1;
      check("rst_in_ready_during", {63'd0, bus.in_ready}, 64'd1);
      @(negedge clock);
      reset_n      = 1'b1;
      bus.in_valid = 1'b0;
      #1;
      check("rst_out_valid_after", {63'd0, bus.out_valid}, 64'd0);
      check("rst_in_ready_after", {63'd0, bus.in_ready}, 64'd1);
      issue(32'h00000003, 5'd1, 2'b00, 4'd14, 32'h00000006, 1, 1);
      drain();
      repeat (10) @(negedge clock);

      // Random soak with random gaps and random backpressure.
      soakOn = 1'b1;
      fork
         begin
            while (soakOn) begin
               @(negedge clock);
               bus.out_ready = ($urandom_range(3) != 0);
            end
            bus.out_ready = 1'b1;
         end
         begin
            for (int i = 0; i < 10000; i++) begin
               if ($urandom_range(3) == 0) @(negedge clock);
               d  = $urandom();
               s  = 5'($urandom_range(31));
               op = 2'($urandom_range(3));
               issue(d, s, op, 4'(i), refModel(d, s, op), 1, 0);
            end
            soakOn = 1'b0;
         end
      join
      drain();
      repeat (10) @(negedge clock);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/shift_rotate_pipe.md
Name: shift_rotate_pipe

Overview:
- Pipelined 32-bit shift/rotate unit for the miner datapath. It serves the SHA-256 sigma/Sigma rotations and the processor ALU shift ops.
- The operation is built from five single-power-of-two shift stages (1, 2, 4, 8, 16 bits). Each stage applies one bit of the shift amount, with a register after every stage.
- It accepts one operation per cycle on a valid/ready handshake and returns results in issue order with fixed latency.

Parameters:
- TAG_W, 4, width of the opaque tag carried alongside each operation (sequencer uses it to route the result).

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  synchronous active-low reset, sampled on the rising edge of clock.
- in_valid  in  1  operation present on in_* this cycle.
- in_ready  out  1  unit accepts the operation this cycle.
- in_data  in  32  operand.
- in_shamt  in  5  shift/rotate amount, 0..31.
- in_op  in  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROTR.
- in_tag  in  TAG_W  passed through unchanged.
- out_valid  out  1  result present on out_*.
- out_ready  in  1  consumer accepts the result this cycle.
- out_data  out  32  result.
- out_tag  out  TAG_W  tag of the operation that produced out_data.

Behaviour:
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Stage structure:
  - Five stages, s0..s4. Stage k applies a shift of 2^k bits when shamt bit k = 1; otherwise it passes data through.
  - Each stage register holds valid, data, remaining shamt bits, op and tag. s4 drives out_*.
- Per-stage shift functions:
  - SLL: shift left, zero-fill the LSBs.
  - SRL: shift right, zero-fill the MSBs.
  - SRA: shift right, fill with the original bit 31. The operand sign is carried down the pipe; once s0 has shifted, each stage reads the current bit 31, which already equals the sign.
  - ROTR: bits shifted out of bit 0 re-enter at bit 31.
- Result equals the single-shot 32-bit operation by in_shamt. in_shamt = 0 returns in_data unchanged for every op.
- Pipeline advance:
  - advance = !out_valid || out_ready. The whole pipe shifts one stage when advance = 1 and holds every register when advance = 0.
  - in_ready = advance, combinational. There is no dependency of in_ready on in_valid.
  - On advance, s0 loads in_valid && in_ready together with the input fields. Data fields of invalid slots are don't-care; valid bits are exact.
- Latency: exactly 5 cycles from input transfer to out_valid, when no stall occurs. Each stall cycle adds one cycle.
- Throughput: 1 op/cycle. Bubbles are not collapsed; a bubble travels down the pipe like an operation.
- Ordering and integrity: results leave in issue order. No operation is dropped or duplicated across any stall pattern.
- Stall hold: while out_valid = 1 and out_ready = 0, out_data and out_tag are held stable.
- Simultaneous in and out transfer in the same cycle is legal and is the normal full-rate case.
- Reset:
  - reset_n = 0 at a rising edge clears all stage valid bits.
  - After that edge: out_valid = 0, out_data = 0, out_tag = 0.
  - in_ready = 1 during and after reset, because out_valid = 0.
  - Operations in flight at reset are discarded and never appear on the output.
  - An in_valid presented while reset_n = 0 is not captured.
- Purely registered output: out_* come straight from s4 registers; there is no combinational path from in_* to out_*.

Test Plan:
- SLL, in_data 0x00000001, shamt 31, out_ready = 1 → out_valid asserts exactly 5 cycles later with out_data 0x80000000 and the matching tag.
- in_data 0x80000000, shamt 4, issued back-to-back:
  - SRA → 0xF8000000.
  - SRL → 0x08000000.
  - Results arrive on consecutive cycles in issue order.
- ROTR cases:
  - 0x12345678 by 8 → 0x78123456.
  - 0x12345678 by 0 → 0x12345678.
  - 0x80000001 by 1 → 0xC0000000.
  - All 32 shamt values for a random word are checked against a reference model.
- Backpressure: issue 8 ops on consecutive cycles (tags 0..7) and hold out_ready = 0 for 4 cycles after the first result appears.
  - in_ready = 0 throughout the stall.
  - out_data and out_tag stay stable during the stall.
  - All 8 results arrive in tag order with no loss or duplication.
- Reset mid-flight: with 3 ops in the pipe, drive reset_n = 0 for one edge.
  - Next cycle: out_valid = 0 and in_ready = 1.
  - None of the 3 results ever appears.
  - A new op issued after reset completes in 5 cycles.
- Random soak: 10k random ops with random in_valid/out_ready → scoreboard matches the reference model and observes no out_* change while stalled.
